// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the commit-stage data-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_port_arbiter_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int STARVE_LIMIT = 4;

  // NORMAL: loads win by default; FORCE_ST: loads locked out until stores drain
  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    FORCE_ST = 1'b1
  } arb_state_e;

  // One memory access as presented on the single port
  typedef struct packed {
    logic                 v;
    logic                 w;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of load, store-drain and memory-port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: ld_ready/st_ready are the accept strobes; no credits.
interface dmem_port_arbiter_if #(
  parameter int W = 16
);
  logic         ld_v;
  logic [W-1:0] ld_addr;
  logic         ld_ready;
  logic         ld_data_v;
  logic [W-1:0] ld_data;
  logic         st_v;
  logic [W-1:0] st_addr;
  logic [W-1:0] st_data;
  logic         st_ready;
  logic         sb_full;
  logic         flush;
  logic         mem_v;
  logic         mem_w;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  // Requesters plus the memory itself
  modport master (
    output ld_v, ld_addr, st_v, st_addr, st_data, sb_full, flush, mem_rdata,
    input  ld_ready, ld_data_v, ld_data, st_ready, mem_v, mem_w, mem_addr, mem_wdata
  );

  // The arbiter
  modport slave (
    input  ld_v, ld_addr, st_v, st_addr, st_data, sb_full, flush, mem_rdata,
    output ld_ready, ld_data_v, ld_data, st_ready, mem_v, mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles a waiting store lost to a load.
// Latency: count updates one cycle after inc/clr; sat is a direct decode.
// Backpressure: none; clear has priority over increment.
module dmem_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Count losses, hold at the limit, drop to zero when the store wins or leaves
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == MAX);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between execute loads and store-buffer drains.
// Latency: memory request combinational from grant; load data one cycle after grant.
// Backpressure: loser sees ready low and holds; flush blocks loads, never stores.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE_P    = WORD_SIZE,
  parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  dmem_port_arbiter_if.slave  bus
);

  arb_state_e state, state_nxt;
  logic       st_grant;
  logic       ld_grant;
  logic       urgent;
  logic       starve_sat;
  logic       resp_pend;
  mem_req_t   req;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decision and next state; grants are held off while reset is asserted
  always_comb begin
    st_grant  = 1'b0;
    ld_grant  = 1'b0;
    state_nxt = state;
    urgent    = bus.sb_full | starve_sat;
    case (state)
      NORMAL: begin
        st_grant = bus.st_v & (~bus.ld_v | urgent);
        ld_grant = bus.ld_v & ~bus.flush & ~st_grant;
        // The first term is unreachable with the grant rule above; it keeps
        // the escape path explicit should the grant rule ever gain a flush term.
        if ((bus.st_v & urgent & ~st_grant) | (bus.sb_full & bus.flush)) begin
          state_nxt = FORCE_ST;
        end
      end
      FORCE_ST: begin
        st_grant = bus.st_v;
        if ((st_grant & ~bus.sb_full) | ~bus.st_v) begin
          state_nxt = NORMAL;
        end
      end
      default: state_nxt = NORMAL;
    endcase
    if (reset_i) begin
      st_grant = 1'b0;
      ld_grant = 1'b0;
    end
  end

  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT_P)
  ) u_starve_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (bus.st_v & ld_grant),
    .clr     (st_grant | ~bus.st_v),
    .sat     (starve_sat)
  );

  // Memory request built directly from whichever side holds the grant
  always_comb begin
    req = '0;
    if (st_grant) begin
      req.v    = 1'b1;
      req.w    = 1'b1;
      req.addr = bus.st_addr;
      req.data = bus.st_data;
    end else if (ld_grant) begin
      req.v    = 1'b1;
      req.w    = 1'b0;
      req.addr = bus.ld_addr;
    end
  end

  // Remember that a read was issued so its data can be flagged next cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_pend <= 1'b0;
    end else begin
      resp_pend <= ld_grant;
    end
  end

  assign bus.mem_v     = req.v;
  assign bus.mem_w     = req.w;
  assign bus.mem_addr  = req.addr;
  assign bus.mem_wdata = req.data;
  assign bus.ld_ready  = ld_grant;
  assign bus.st_ready  = st_grant;
  // A flush arriving with the returning data kills it on the spot
  assign bus.ld_data_v = resp_pend & ~bus.flush & ~reset_i;
  assign bus.ld_data   = bus.ld_data_v ? bus.mem_rdata : '0;

endmodule
